// File: rtl/xga_syncgen_pkg.sv
// XGA 1024x768@60 raster timing defaults and shared types
// for the sync generator and its delay line.
package xga_syncgen_pkg;

  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;
  localparam int ADDR_W = 20;

  localparam int XGA_HACTIVE = 1024;
  localparam int XGA_HFRONT  = 24;
  localparam int XGA_HWIDTH  = 136;
  localparam int XGA_HBACK   = 160;
  localparam int XGA_VACTIVE = 768;
  localparam int XGA_VFRONT  = 3;
  localparam int XGA_VWIDTH  = 6;
  localparam int XGA_VBACK   = 29;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       de;
    logic       fstart;
    logic [2:0] bar;
  } sync_bus_t;

  localparam sync_bus_t SYNC_IDLE =
    '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0};

  // white, yellow, cyan, green, magenta, red, blue, black
  function automatic rgb444_t bar_rgb(
    input logic [2:0] bar
  );
    rgb444_t c;
    c.r = {4{~bar[1]}};
    c.g = {4{~bar[2]}};
    c.b = {4{~bar[0]}};
    return c;
  endfunction

endpackage

// File: rtl/xga_syncgen_delay.sv
// Fixed-depth shift register for the sync bundle, reset to idle.
// Depth 0 is a plain pass-through.
module sync_delay
  import xga_syncgen_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  sync_bus_t d,
  output sync_bus_t q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk;
    assign unused_clk = clk ^ rst_n;
    assign q = d;
  end else begin : g_pipe
    sync_bus_t sr [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          sr[i] <= SYNC_IDLE;
        end
      end else begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) begin
          sr[i] <= sr[i-1];
        end
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/xga_syncgen.sv
// XGA raster sync generator with VRAM read-ahead addressing.
// Optional colour-bar output under SYNCGEN_TEST_PATTERN_EN.
module xga_syncgen
  import xga_syncgen_pkg::*;
#(
  parameter int HACTIVE = XGA_HACTIVE,
  parameter int HFRONT  = XGA_HFRONT,
  parameter int HWIDTH  = XGA_HWIDTH,
  parameter int HBACK   = XGA_HBACK,
  parameter int VACTIVE = XGA_VACTIVE,
  parameter int VFRONT  = XGA_VFRONT,
  parameter int VWIDTH  = XGA_VWIDTH,
  parameter int VBACK   = XGA_VBACK,
  parameter int RD_LAT  = 2
) (
  input  logic              PCK,
  input  logic              RST_N,
  output logic              RDREQ,
  output logic [ADDR_W-1:0] RDADDR,
  output logic              PHSYNC,
  output logic              PVSYNC,
  output logic              PDE,
  output logic              FRAME_START
`ifdef SYNCGEN_TEST_PATTERN_EN
  ,
  output logic [3:0]        TPAT_R,
  output logic [3:0]        TPAT_G,
  output logic [3:0]        TPAT_B
`endif
);

  localparam int HPERIOD =
    HACTIVE + HFRONT + HWIDTH + HBACK;
  localparam int VPERIOD =
    VACTIVE + VFRONT + VWIDTH + VBACK;

  if (RD_LAT < 0 || RD_LAT > 7 ||
      HACTIVE == 0 || HFRONT == 0 ||
      HWIDTH == 0 || HBACK == 0 ||
      VACTIVE == 0 || VFRONT == 0 ||
      VWIDTH == 0 || VBACK == 0 ||
      HPERIOD > (1 << HCNT_W) ||
      VPERIOD > (1 << VCNT_W)) begin : g_bad_cfg
    $error("xga_syncgen: illegal configuration");
  end

  localparam logic [HCNT_W-1:0] H_ACT =
    HCNT_W'(HACTIVE);
  localparam logic [HCNT_W-1:0] H_SB =
    HCNT_W'(HACTIVE + HFRONT);
  localparam logic [HCNT_W-1:0] H_SE =
    HCNT_W'(HACTIVE + HFRONT + HWIDTH);
  localparam logic [HCNT_W-1:0] H_LAST =
    HCNT_W'(HPERIOD - 1);
  localparam logic [VCNT_W-1:0] V_ACT =
    VCNT_W'(VACTIVE);
  localparam logic [VCNT_W-1:0] V_SB =
    VCNT_W'(VACTIVE + VFRONT);
  localparam logic [VCNT_W-1:0] V_SE =
    VCNT_W'(VACTIVE + VFRONT + VWIDTH);
  localparam logic [VCNT_W-1:0] V_LAST =
    VCNT_W'(VPERIOD - 1);

  logic [HCNT_W-1:0] hc;
  logic [VCNT_W-1:0] vc;
  logic              hwrap;
  logic              vwrap;
  logic              act;
  logic              first;
  sync_bus_t         s1;
  sync_bus_t         dq;

  assign hwrap = (hc == H_LAST);
  assign vwrap = (vc == V_LAST);
  assign act   = (hc < H_ACT) && (vc < V_ACT);
  assign first = (hc == '0) && (vc == '0);

  always_ff @(posedge PCK or negedge RST_N) begin
    if (!RST_N) begin
      hc <= '0;
      vc <= '0;
    end else if (hwrap) begin
      hc <= '0;
      vc <= vwrap ? '0 : vc + VCNT_W'(1);
    end else begin
      hc <= hc + HCNT_W'(1);
    end
  end

  // Address is a running count; it restarts on pixel (0,0)
  // and otherwise advances only on issued requests.
  always_ff @(posedge PCK or negedge RST_N) begin
    if (!RST_N) begin
      RDREQ  <= 1'b0;
      RDADDR <= '0;
      s1     <= SYNC_IDLE;
    end else begin
      RDREQ <= act;
      if (act) begin
        RDADDR <= first ? '0 : RDADDR + ADDR_W'(1);
      end
      s1.hsync  <= !((hc >= H_SB) && (hc < H_SE));
      s1.vsync  <= !((vc >= V_SB) && (vc < V_SE));
      s1.de     <= act;
      s1.fstart <= first;
      s1.bar    <= hc[9:7];
    end
  end

  sync_delay #(
    .DEPTH (RD_LAT)
  ) u_dly (
    .clk   (PCK),
    .rst_n (RST_N),
    .d     (s1),
    .q     (dq)
  );

  assign PHSYNC      = dq.hsync;
  assign PVSYNC      = dq.vsync;
  assign PDE         = dq.de;
  assign FRAME_START = dq.fstart;

`ifdef SYNCGEN_TEST_PATTERN_EN
  rgb444_t pix;

  always_comb begin
    pix = '0;
    if (dq.de) begin
      pix = bar_rgb(dq.bar);
    end
  end

  assign TPAT_R = pix.r;
  assign TPAT_G = pix.g;
  assign TPAT_B = pix.b;
`else
  logic unused_bar;
  assign unused_bar = ^dq.bar;
`endif

endmodule

// File: tb/tb_xga_syncgen.sv
// Directed bench for xga_syncgen: full XGA timing on one
// instance, reduced raster on three latency variants.
module tb_xga_syncgen;

  localparam int SHA = 16;
  localparam int SHF = 2;
  localparam int SHW = 3;
  localparam int SHB = 4;
  localparam int SVA = 6;
  localparam int SVF = 1;
  localparam int SVW = 2;
  localparam int SVB = 3;
  localparam int SHP = SHA + SHF + SHW + SHB;
  localparam int SVP = SVA + SVF + SVW + SVB;
  localparam int KMAX = 1400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        rq [4];
  logic [19:0] ad [4];
  logic        hs [4];
  logic        vs [4];
  logic        de [4];
  logic        fs [4];
`ifdef SYNCGEN_TEST_PATTERN_EN
  logic [3:0]  tpr [4];
  logic [3:0]  tpg [4];
  logic [3:0]  tpb [4];
`endif

  int tests;
  int fails;

  xga_syncgen #(.RD_LAT(2)) dut_a (
    .PCK(clk), .RST_N(rst_n),
    .RDREQ(rq[0]), .RDADDR(ad[0]),
    .PHSYNC(hs[0]), .PVSYNC(vs[0]),
    .PDE(de[0]), .FRAME_START(fs[0])
`ifdef SYNCGEN_TEST_PATTERN_EN
    , .TPAT_R(tpr[0]), .TPAT_G(tpg[0]), .TPAT_B(tpb[0])
`endif
  );

  xga_syncgen #(
    .HACTIVE(SHA), .HFRONT(SHF), .HWIDTH(SHW), .HBACK(SHB),
    .VACTIVE(SVA), .VFRONT(SVF), .VWIDTH(SVW), .VBACK(SVB),
    .RD_LAT(2)
  ) dut_b (
    .PCK(clk), .RST_N(rst_n),
    .RDREQ(rq[1]), .RDADDR(ad[1]),
    .PHSYNC(hs[1]), .PVSYNC(vs[1]),
    .PDE(de[1]), .FRAME_START(fs[1])
`ifdef SYNCGEN_TEST_PATTERN_EN
    , .TPAT_R(tpr[1]), .TPAT_G(tpg[1]), .TPAT_B(tpb[1])
`endif
  );

  xga_syncgen #(
    .HACTIVE(SHA), .HFRONT(SHF), .HWIDTH(SHW), .HBACK(SHB),
    .VACTIVE(SVA), .VFRONT(SVF), .VWIDTH(SVW), .VBACK(SVB),
    .RD_LAT(0)
  ) dut_c (
    .PCK(clk), .RST_N(rst_n),
    .RDREQ(rq[2]), .RDADDR(ad[2]),
    .PHSYNC(hs[2]), .PVSYNC(vs[2]),
    .PDE(de[2]), .FRAME_START(fs[2])
`ifdef SYNCGEN_TEST_PATTERN_EN
    , .TPAT_R(tpr[2]), .TPAT_G(tpg[2]), .TPAT_B(tpb[2])
`endif
  );

  xga_syncgen #(
    .HACTIVE(SHA), .HFRONT(SHF), .HWIDTH(SHW), .HBACK(SHB),
    .VACTIVE(SVA), .VFRONT(SVF), .VWIDTH(SVW), .VBACK(SVB),
    .RD_LAT(5)
  ) dut_d (
    .PCK(clk), .RST_N(rst_n),
    .RDREQ(rq[3]), .RDADDR(ad[3]),
    .PHSYNC(hs[3]), .PVSYNC(vs[3]),
    .PDE(de[3]), .FRAME_START(fs[3])
`ifdef SYNCGEN_TEST_PATTERN_EN
    , .TPAT_R(tpr[3]), .TPAT_G(tpg[3]), .TPAT_B(tpb[3])
`endif
  );

  typedef struct {
    string       nm;
    int          u;
    int          k;
    logic        rq;
    logic [19:0] ad;
    logic        de;
    logic        fs;
    logic        hs;
    logic        vs;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(
    input string nm, input int u, input int k,
    input logic r, input int a, input logic d,
    input logic f, input logic h, input logic v
  );
    vec_t t;
    t.nm = nm; t.u = u; t.k = k;
    t.rq = r; t.ad = 20'(a); t.de = d;
    t.fs = f; t.hs = h; t.vs = v;
    tbl.push_back(t);
  endfunction

  function automatic logic [24:0] tup(input int u);
    return {rq[u], ad[u], de[u], fs[u], hs[u], vs[u]};
  endfunction

  function automatic int lat(input int u);
    return (u == 1) ? 2 : (u == 2) ? 0 : 5;
  endfunction

  // reference raster for the reduced timing, from absolute index n
  function automatic void sm_ref(
    input int n, output logic act, output logic [19:0] adr,
    output logic h, output logic v, output logic f
  );
    int hh;
    int vv;
    hh  = n % SHP;
    vv  = (n / SHP) % SVP;
    act = (hh < SHA) && (vv < SVA);
    adr = 20'(vv * SHA + hh);
    h   = !((hh >= SHA + SHF) && (hh < SHA + SHF + SHW));
    v   = !((vv >= SVA + SVF) && (vv < SVA + SVF + SVW));
    f   = (hh == 0) && (vv == 0);
  endfunction

  task automatic chk(
    input string nm, input int k,
    input logic [31:0] got, input logic [31:0] exp
  );
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at k=%0d: got 0x%0h, expected 0x%0h",
               nm, k, got, exp);
    end
  endtask

  task automatic run_pass();
    int de_n, hs_n, de_fall, hs_fall, r1, r2;
    int fs_n, vs_n, rise_b, fs1, fs2;
    logic pde_a, phs_a, pde_b;
    int err [4];
    int fk [4];
    logic [19:0] eadr;
    logic ea, eh, ev, ef;
    logic [19:0] ead;
    de_n = 0; hs_n = 0; de_fall = -1; hs_fall = -1;
    r1 = -1; r2 = -1; fs_n = 0; vs_n = 0; rise_b = 0;
    fs1 = -1; fs2 = -1;
    pde_a = 1'b0; phs_a = 1'b1; pde_b = 1'b0;
    eadr = '0; ea = 1'b0;
    for (int i = 0; i < 4; i++) begin
      err[i] = 0;
      fk[i] = -1;
    end
    for (int k = 0; k <= KMAX; k++) begin
      if (k > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      foreach (tbl[i]) begin
        if (tbl[i].k == k) begin
          chk(tbl[i].nm, k, 32'(tup(tbl[i].u)),
              32'({tbl[i].rq, tbl[i].ad, tbl[i].de,
                   tbl[i].fs, tbl[i].hs, tbl[i].vs}));
        end
      end
`ifdef SYNCGEN_TEST_PATTERN_EN
      if (k == 131)
        chk("tpat_bar1", k, 32'({tpr[0], tpg[0], tpb[0]}), 32'hFF0);
      if (k == 1030)
        chk("tpat_blank", k, 32'({tpr[0], tpg[0], tpb[0]}), 32'h0);
`endif
      if (k >= 1 && k <= 1344) begin
        if (de[0]) de_n++;
        if (!hs[0]) hs_n++;
        if (pde_a && !de[0] && de_fall < 0) de_fall = k;
        if (phs_a && !hs[0] && hs_fall < 0) hs_fall = k;
      end
      if (!pde_a && de[0]) begin
        if (r1 < 0) r1 = k;
        else if (r2 < 0) r2 = k;
      end
      pde_a = de[0];
      phs_a = hs[0];
      if (k >= 1 && k <= 600) begin
        if (fs[1]) begin
          fs_n++;
          if (fs1 < 0) fs1 = k;
          else if (fs2 < 0) fs2 = k;
        end
        if (!vs[1]) vs_n++;
        if (!pde_b && de[1]) rise_b++;
      end
      pde_b = de[1];
      if (k >= 1) begin
        sm_ref(k - 1, ea, ead, eh, ev, ef);
        if (ea) eadr = ead;
      end
      for (int u = 1; u < 4; u++) begin
        logic [24:0] e;
        logic [3:0]  es;
        logic        xa, xh, xv, xf;
        logic [19:0] xd;
        int          m;
        m = k - 1 - lat(u);
        es = 4'b0011;
        if (k >= 1 && m >= 0) begin
          sm_ref(m, xa, xd, xh, xv, xf);
          es = {xa, xf, xh, xv};
        end
        e = {(k >= 1) ? ea : 1'b0, eadr, es};
        if (tup(u) !== e) begin
          err[u]++;
          if (fk[u] < 0) fk[u] = k;
        end
      end
    end
    chk("a_de_count", 1344, 32'(de_n), 32'd1024);
    chk("a_hs_count", 1344, 32'(hs_n), 32'd136);
    chk("a_hs_after_de", hs_fall, 32'(hs_fall - de_fall), 32'd24);
    chk("a_line_period", r2, 32'(r2 - r1), 32'd1344);
    chk("b_fs_count", 600, 32'(fs_n), 32'd2);
    chk("b_frame_period", fs2, 32'(fs2 - fs1), 32'd300);
    chk("b_vs_low", 600, 32'(vs_n), 32'd100);
    chk("b_de_lines", 600, 32'(rise_b), 32'd12);
    chk("trace_lat2", fk[1], 32'(err[1]), 32'd0);
    chk("trace_lat0", fk[2], 32'(err[2]), 32'd0);
    chk("trace_lat5", fk[3], 32'(err[3]), 32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    //   name          u  k     rq ad    de fs hs vs
    add("reset",       0, 0,    0, 0,    0, 0, 1, 1);
    add("first_req",   0, 1,    1, 0,    0, 0, 1, 1);
    add("second_req",  0, 2,    1, 1,    0, 0, 1, 1);
    add("pde_rise",    0, 3,    1, 2,    1, 1, 1, 1);
    add("fs_width",    0, 4,    1, 3,    1, 0, 1, 1);
    add("last_req_l0", 0, 1024, 1, 1023, 1, 0, 1, 1);
    add("req_end",     0, 1025, 0, 1023, 1, 0, 1, 1);
    add("de_last",     0, 1026, 0, 1023, 1, 0, 1, 1);
    add("de_fall",     0, 1027, 0, 1023, 0, 0, 1, 1);
    add("hs_pre",      0, 1050, 0, 1023, 0, 0, 1, 1);
    add("hs_fall",     0, 1051, 0, 1023, 0, 0, 0, 1);
    add("hs_last",     0, 1186, 0, 1023, 0, 0, 0, 1);
    add("hs_rise",     0, 1187, 0, 1023, 0, 0, 1, 1);
    add("line1_req",   0, 1345, 1, 1024, 0, 0, 1, 1);
    add("line1_req2",  0, 1346, 1, 1025, 0, 0, 1, 1);
    add("line1_de",    0, 1347, 1, 1026, 1, 0, 1, 1);
    add("b_hold",      1, 20,   0, 15,   0, 0, 1, 1);
    add("b_last_addr", 1, 141,  1, 95,   1, 0, 1, 1);
    add("b_addr_held", 1, 142,  0, 95,   1, 0, 1, 1);
    add("b_vs_pre",    1, 177,  0, 95,   0, 0, 1, 1);
    add("b_vs_fall",   1, 178,  0, 95,   0, 0, 1, 0);
    add("b_wrap_addr", 1, 301,  1, 0,    0, 0, 1, 1);
    add("b_fs2",       1, 303,  1, 2,    1, 1, 1, 1);
    add("c_aligned",   2, 1,    1, 0,    1, 1, 1, 1);
    add("d_pre",       3, 5,    1, 4,    0, 0, 1, 1);
    add("d_rise",      3, 6,    1, 5,    1, 1, 1, 1);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_pass();

    repeat (180) @(posedge clk);
    #1;
    chk("busy_a", 1580, 32'({rq[0], ad[0], de[0]}),
        32'({1'b1, 20'd1259, 1'b1}));
    chk("busy_b", 1580, 32'({rq[1], ad[1]}),
        32'({1'b1, 20'd52}));
    #1 rst_n = 1'b0;
    #1;
    for (int u = 0; u < 4; u++) begin
      chk("async_idle", u, 32'(tup(u)), 32'd3);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_pass();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
